serial_alu: RTL and testbench
=============================

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to begin an operation; sampled only when ready.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, sampled with start.
REQ-007 The block SHALL have port c_in  input  1  carry-in for ADD, sampled with start.
REQ-008 The block SHALL have port op_code  input  3  operation select, sampled with start.
REQ-009 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when result and flags become valid.
REQ-011 The block SHALL have port o  output  WIDTH  registered result.
REQ-012 The block SHALL have port p  output  1  parity flag: XOR of all bits of o.
REQ-013 The block SHALL have port z  output  1  zero flag: high when o is all zeros.
REQ-014 The block SHALL have port c_out  output  1  carry-out of the final bit.

Function
REQ-015 Op codes SHALL be: 000 ADD (a+b+c_in), 001 SUB (a+~b+1, c_in ignored), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 PASS A, 111 PASS B.
REQ-016 For the logic and pass ops (010-111), c_out SHALL be 0.
REQ-017 Computation SHALL be bit-serial, LSB first, one bit per clock, with the carry held in a 1-bit register between bits.
REQ-018 The FSM SHALL have states IDLE, RUN and DONE; ready SHALL be defined as state IDLE or DONE.
REQ-019 FSM transitions:
- ready with start=1: latch a, b, c_in and op_code; clear the bit counter; go to RUN.
- ready with start=0: go to IDLE.
- RUN: after exactly WIDTH bit-cycles, go to DONE.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 done SHALL be 1 exactly in DONE; the first done edge SHALL come WIDTH+1 rising edges after the edge that sampled start.
REQ-022 o, p, z and c_out SHALL update only on entry to DONE and SHALL hold their values until the next entry to DONE.
REQ-023 start while busy=1 SHALL be ignored: no operand re-latch, no effect on the current operation.
REQ-024 start during the DONE cycle SHALL be accepted (back-to-back); done still pulses for exactly one cycle.
REQ-025 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and busy, done, o, p, z, c_out and the carry register SHALL all be 0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow the release of reset.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n is released.

Structure
REQ-029 Package serial_alu_pkg SHALL hold the op_code constants and the FSM state encoding.
REQ-030 The single-bit datapath SHALL be sub-module alu_slice (inputs a, b, c_in, op_code; outputs o, c_out), instantiated once.
REQ-031 The operand and result shift registers, the counter and the FSM SHALL live in serial_alu.

Verification (WIDTH=8)
REQ-032 ADD a=FF, b=01, c_in=0 -> o=00, c_out=1, z=1, p=0; done on the 9th edge after start was sampled.
REQ-033 SUB a=05, b=07 -> o=FE, c_out=0, z=0, p=1.
REQ-034 ADD a=10, b=20, then start pulsed again with XOR mid-RUN -> o=30, one done pulse, second request ignored.
REQ-035 Reset pulsed at bit 4 of a RUN -> all outputs 0 immediately, no done pulse afterwards.
REQ-036 AND a=F0, b=3C with start held through DONE, then OR a=0F, b=F0 -> o=30, then done again 9 edges later with o=FF, p=0.
REQ-037 Randomised run of 1000 ops across all op codes and WIDTH in {2, 8, 32}, checked against a reference model; o, p, z and c_out SHALL all match.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared definitions for the bit-serial ALU: op_code values, FSM state
//   encoding and the helper that picks the carry seeded into the carry
//   register when an operation is accepted.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,  // a + b + c_in
        OP_SUB   = 3'b001,  // a + ~b + 1
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOTA  = 3'b101,
        OP_PASSA = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // SUB is a + ~b with the +1 supplied as the initial carry; logic and
    // pass ops start with no carry so c_out ends at 0.
    function automatic logic init_carry(input logic [2:0] op, input logic c_in);
        logic c;
        c = 1'b0;
        if (op == OP_ADD) c = c_in;
        if (op == OP_SUB) c = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice
//   One-bit combinational ALU datapath used by serial_alu, one bit per clock.
//   Ports:
//     a, b     : operand bits
//     c_in     : carry into this bit (from the carry register)
//     op_code  : operation select (serial_alu_pkg::op_e values)
//     o        : result bit
//     c_out    : carry out of this bit (0 for logic / pass ops)
module alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic [2:0] op_code,
    output logic       o,
    output logic       c_out
);

    logic bx;

    always_comb begin
        // SUB reuses the adder with B inverted.
        bx    = (op_code == OP_SUB) ? ~b : b;
        o     = 1'b0;
        c_out = 1'b0;
        case (op_code)
            OP_ADD, OP_SUB: begin
                o     = a ^ bx ^ c_in;
                c_out = (a & bx) | (a & c_in) | (bx & c_in);
            end
            OP_AND:   o = a & b;
            OP_OR:    o = a | b;
            OP_XOR:   o = a ^ b;
            OP_NOTA:  o = ~a;
            OP_PASSA: o = a;
            OP_PASSB: o = b;
            default: begin
                o     = 1'b0;
                c_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// serial_alu
//   Bit-serial ALU: operands are latched with start, processed LSB first one
//   bit per clock through alu_slice, and the result plus flags are committed
//   to registered outputs on entry to DONE.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     start                : begin an operation (honoured only in IDLE/DONE)
//     a, b, c_in, op_code  : operands, carry-in, op select (sampled with start)
//     busy                 : high in RUN
//     done                 : one-cycle pulse in DONE
//     o, p, z, c_out       : result, parity, zero flag, final carry
//   Timing: the start edge latches operands, the next WIDTH edges process
//   one bit each, and one further edge commits the result, so done rises
//   WIDTH+1 edges after the start edge.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       op_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             p,
    output logic             z,
    output logic             c_out
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;   // all WIDTH bits processed; next RUN edge commits

    logic bit_d, carry_d;

    alu_slice u_slice (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .c_in    (carry_q),
        .op_code (op_q),
        .o       (bit_d),
        .c_out   (carry_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            o       <= '0;
            p       <= 1'b0;
            z       <= 1'b0;
            c_out   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op_code;
                        carry_q <= init_carry(op_code, c_in);
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (last_q) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        o       <= res_q;
                        p       <= ^res_q;
                        z       <= (res_q == '0);
                        c_out   <= carry_q;
                    end else begin
                        // Result bits enter at the MSB so the word is in
                        // place after WIDTH shifts.
                        a_q     <= a_q >> 1;
                        b_q     <= b_q >> 1;
                        res_q   <= {bit_d, res_q[WIDTH-1:1]};
                        carry_q <= carry_d;
                        // Counter holds at its last value rather than wrapping.
                        if (cnt_q == LAST_BIT) last_q <= 1'b1;
                        else                   cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

    typedef struct packed {
        logic [31:0] o;
        logic        p;
        logic        z;
        logic        c;
    } ref_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] eo;
        logic       ec, ez, ep;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int rnd_fin = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rrst_n;
    logic       start, c_in;
    logic [7:0] a, b, o;
    logic [2:0] op_code;
    logic       busy, done, p, z, c_out;

    serial_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
        .op_code(op_code), .busy(busy), .done(done), .o(o), .p(p), .z(z),
        .c_out(c_out)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference: plain integer arithmetic on the whole word.
    function automatic ref_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] ia, input logic [31:0] ib, input logic cin);
        logic [63:0] mask, full, r, a64, b64;
        ref_t res;
        mask = (64'd1 << w) - 64'd1;
        a64  = {32'd0, ia} & mask;
        b64  = {32'd0, ib} & mask;
        case (op)
            3'd0: full = a64 + b64 + {63'd0, cin};
            3'd1: full = a64 + (~b64 & mask) + 64'd1;
            3'd2: full = a64 & b64;
            3'd3: full = a64 | b64;
            3'd4: full = a64 ^ b64;
            3'd5: full = ~a64 & mask;
            3'd6: full = a64;
            default: full = b64;
        endcase
        r     = full & mask;
        res.o = r[31:0];
        res.c = (op <= 3'd1) ? full[w] : 1'b0;
        res.p = ^r;
        res.z = (r == 64'd0);
        return res;
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, output int lat);
        @(negedge clk);
        op_code = op; a = ia; b = ib; c_in = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        wait_done(lat);
    endtask

    // Randomised instances at several widths, each with its own process.
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 2 : (g == 1) ? 8 : 32;
        logic         st, rc, rbusy, rdone, rp, rz, rco;
        logic [W-1:0] ra, rb, ro;
        logic [2:0]   rop;

        serial_alu #(.WIDTH(W)) u_rnd (
            .clk(clk), .rst_n(rrst_n), .start(st), .a(ra), .b(rb), .c_in(rc),
            .op_code(rop), .busy(rbusy), .done(rdone), .o(ro), .p(rp), .z(rz),
            .c_out(rco)
        );

        initial begin
            ref_t e;
            int   lat;
            st = 1'b0; ra = '0; rb = '0; rc = 1'b0; rop = '0;
            @(posedge rrst_n);
            for (int n = 0; n < 340; n++) begin
                @(negedge clk);
                ra  = W'($urandom);
                rb  = W'($urandom);
                rc  = 1'($urandom);
                rop = 3'($urandom);
                e   = model(W, rop, 32'(ra), 32'(rb), rc);
                st  = 1'b1;
                @(posedge clk); #1;
                st  = 1'b0;
                lat = -1;
                for (int k = 1; k <= W + 5; k++) begin
                    @(posedge clk); #1;
                    if (rdone) begin lat = k; break; end
                end
                chk($sformatf("rnd_w%0d_latency op%0d", W, rop), 64'(lat), 64'(W + 1));
                chk($sformatf("rnd_w%0d_o op%0d a=%0h b=%0h", W, rop, ra, rb), 64'(ro), 64'(e.o));
                chk($sformatf("rnd_w%0d_p op%0d", W, rop), 64'(rp), 64'(e.p));
                chk($sformatf("rnd_w%0d_z op%0d", W, rop), 64'(rz), 64'(e.z));
                chk($sformatf("rnd_w%0d_c op%0d a=%0h b=%0h", W, rop, ra, rb), 64'(rco), 64'(e.c));
            end
            rnd_fin++;
        end
    end

    initial begin
        vec_t vt[12];
        int   lat, ndone, first;
        logic [7:0] o_first;

        //          op    a      b      cin   o      c     z     p
        vt[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{3'd1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{3'd0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{3'd1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{3'd3, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{3'd4, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'd5, 8'h0F, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{3'd6, 8'h81, 8'h42, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3'd7, 8'hC3, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1};
        vt[10] = '{3'd7, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[11] = '{3'd0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; rrst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; c_in = 1'b0; op_code = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_o", o, 0);
        chk("reset_p", p, 0);
        chk("reset_z", z, 0);
        chk("reset_c", c_out, 0);

        // Start presented together with reset release: taken on the first edge.
        @(negedge clk);
        rst_n = 1'b1; rrst_n = 1'b1;
        op_code = 3'd6; a = 8'h5A; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_start_busy", busy, 1);
        wait_done(lat);
        chk("first_start_latency", 64'(lat), 64'd9);
        chk("first_start_o", o, 8'h5A);

        // Table vectors, issued back-to-back from the DONE cycle.
        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
            chk($sformatf("vec%0d_o", i), o, vt[i].eo);
            chk($sformatf("vec%0d_c", i), c_out, vt[i].ec);
            chk($sformatf("vec%0d_z", i), z, vt[i].ez);
            chk($sformatf("vec%0d_p", i), p, vt[i].ep);
        end

        // Second start while busy is ignored.
        @(negedge clk);
        op_code = 3'd0; a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        op_code = 3'd4; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first = -1; o_first = '0;
        for (int k = 5; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) begin first = k; o_first = o; end
            end
        end
        chk("ignore_start_latency", 64'(first), 64'd9);
        chk("ignore_start_done_count", 64'(ndone), 64'd1);
        chk("ignore_start_o", o_first, 8'h30);
        chk("ignore_start_busy_after", busy, 0);

        // Leave nonzero outputs, then reset mid-RUN.
        run_op(3'd0, 8'h80, 8'h80, 1'b1, lat);
        chk("pre_reset_o", o, 8'h01);
        @(negedge clk);
        op_code = 3'd0; a = 8'hFF; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_o", o, 0);
        chk("abort_p", p, 0);
        chk("abort_z", z, 0);
        chk("abort_c", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // Start held through DONE: AND, then OR accepted from DONE.
        @(negedge clk);
        op_code = 3'd2; a = 8'hF0; b = 8'h3C; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op_code = 3'd3; a = 8'h0F; b = 8'hF0;
        chk("held_busy", busy, 1);
        wait_done(lat);
        chk("held_and_latency", 64'(lat), 64'd9);
        chk("held_and_o", o, 8'h30);
        @(posedge clk); #1;
        chk("held_done_one_cycle", done, 0);
        chk("held_rerun_busy", busy, 1);
        chk("held_o_holds", o, 8'h30);
        start = 1'b0;
        wait_done(lat);
        chk("held_or_latency", 64'(lat), 64'd9);
        chk("held_or_o", o, 8'hFF);
        chk("held_or_p", p, 0);
        chk("held_or_z", z, 0);
        chk("held_or_c", c_out, 0);

        for (int k = 0; k < 60000 && rnd_fin < 3; k++) @(posedge clk);
        chk("random_runs_complete", 64'(rnd_fin), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
